// File: rtl/tour_cmd_seq_if.sv
// Signal bundle linking the tour sequencer to the solver, the UART wrapper and the command processor.
interface tour_cmd_seq_if;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        resp_out;
  logic        tour_busy;

  modport slave (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp_out, tour_busy
  );

  modport master (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp_out, tour_busy
  );
endinterface

// File: rtl/tour_cmd_seq.sv
// Turns a solved knight's tour into vertical/horizontal drive commands; passes UART
// commands straight through to the command processor whenever no tour is running.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES = 24,
  parameter logic [3:0]  MV_OP     = 4'b0010,
  parameter logic [3:0]  FAN_OP    = 4'b0011
) (
  input  logic          clk,
  input  logic          rst,
  tour_cmd_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_e;

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  state_e      state_q;
  logic [4:0]  mv_indx_q;
  logic        tour_busy_q;

  logic [1:0]  dx_mag, dy_mag;
  logic        dx_pos, dy_pos;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  // Lowest set bit wins; an all-zero move leaves both legs at zero squares.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    dx_mag = 2'd0;
    dy_mag = 2'd0;
    dx_pos = 1'b0;
    dy_pos = 1'b0;
    casez (bus.move)
      8'b???????1: begin dx_mag = 2'd1; dx_pos = 1'b0; dy_mag = 2'd2; dy_pos = 1'b1; end
      8'b??????10: begin dx_mag = 2'd1; dx_pos = 1'b1; dy_mag = 2'd2; dy_pos = 1'b1; end
      8'b?????100: begin dx_mag = 2'd2; dx_pos = 1'b0; dy_mag = 2'd1; dy_pos = 1'b1; end
      8'b????1000: begin dx_mag = 2'd2; dx_pos = 1'b0; dy_mag = 2'd1; dy_pos = 1'b0; end
      8'b???10000: begin dx_mag = 2'd1; dx_pos = 1'b0; dy_mag = 2'd2; dy_pos = 1'b0; end
      8'b??100000: begin dx_mag = 2'd1; dx_pos = 1'b1; dy_mag = 2'd2; dy_pos = 1'b0; end
      8'b?1000000: begin dx_mag = 2'd2; dx_pos = 1'b1; dy_mag = 2'd1; dy_pos = 1'b0; end
      8'b10000000: begin dx_mag = 2'd2; dx_pos = 1'b1; dy_mag = 2'd1; dy_pos = 1'b1; end
      default: ;
    endcase
  end

  assign vert_cmd  = {MV_OP,  (dy_pos ? 8'h00 : 8'h7F), 2'b00, dy_mag};
  assign horz_cmd  = {FAN_OP, (dx_pos ? 8'hBF : 8'h3F), 2'b00, dx_mag};
  assign last_move = (mv_indx_q == LAST_INDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mv_indx_q   <= 5'd0;
      tour_busy_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      unique case (state_q)
        IDLE: if (bus.start_tour) begin
          state_q     <= VERT;
          mv_indx_q   <= 5'd0;
          tour_busy_q <= 1'b1;
        end
        VERT:   if (bus.clr_cmd_rdy) state_q <= WAIT_V;
        WAIT_V: if (bus.send_resp)   state_q <= HORZ;
        HORZ:   if (bus.clr_cmd_rdy) state_q <= WAIT_H;
        WAIT_H: if (bus.send_resp) begin
          if (last_move) begin
            state_q     <= IDLE;
            tour_busy_q <= 1'b0;
          end else begin
            state_q   <= VERT;
            mv_indx_q <= mv_indx_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outside IDLE the UART side is held off and only the final tour response escapes.
  always_comb begin
    bus.cmd              = bus.cmd_UART;
    bus.cmd_rdy          = bus.cmd_rdy_UART;
    bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
    bus.resp_out         = bus.send_resp;
    if (state_q != IDLE) begin
      bus.clr_cmd_rdy_UART = 1'b0;
      bus.resp_out         = 1'b0;
      bus.cmd_rdy          = 1'b0;
      bus.cmd              = vert_cmd;
    end
    case (state_q)
      VERT:    bus.cmd_rdy = 1'b1;
      HORZ:    begin bus.cmd = horz_cmd; bus.cmd_rdy = 1'b1; end
      WAIT_H:  begin bus.cmd = horz_cmd; bus.resp_out = bus.send_resp & last_move; end
      default: ;
    endcase
  end

  assign bus.mv_indx   = mv_indx_q;
  assign bus.tour_busy = tour_busy_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench: IDLE passthrough vectors, a one-move tour, a full 24-move tour with a
// pending UART command, and a reset in the middle of a tour.
module tb_tour_cmd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tour_cmd_seq_if if24 ();
  tour_cmd_seq_if if1 ();

  tour_cmd_seq #(.NUM_MOVES(24)) u_dut24 (.clk(clk), .rst(rst), .bus(if24));
  tour_cmd_seq #(.NUM_MOVES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));

  // Solver model: combinational lookup addressed by mv_indx.
  logic [7:0] tour_tbl [32];
  assign if24.move = tour_tbl[if24.mv_indx];
  assign if1.move  = 8'h02;

  logic [15:0] exp_v [8];
  logic [15:0] exp_h [8];

  int total = 0;
  int bad   = 0;
  int resp_cnt;

  typedef struct {
    logic [15:0] cmd_uart;
    logic        rdy_uart;
    logic        clr;
    logic        resp;
    logic [15:0] e_cmd;
    logic        e_rdy;
    logic        e_clr_uart;
    logic        e_resp;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One leg on the 24-move DUT: check command, accept it, then respond.
  task automatic leg(input string nm, input logic [15:0] exp_cmd, input logic [4:0] idx,
                     input logic exp_resp);
    check({nm, " cmd"}, if24.cmd, exp_cmd);
    check({nm, " cmd_rdy"}, {15'd0, if24.cmd_rdy}, 16'd1);
    check({nm, " mv_indx"}, {11'd0, if24.mv_indx}, {11'd0, idx});
    check({nm, " busy"}, {15'd0, if24.tour_busy}, 16'd1);
    if24.clr_cmd_rdy = 1'b1;
    #1;
    check({nm, " clr_uart held"}, {15'd0, if24.clr_cmd_rdy_UART}, 16'd0);
    tick();
    if24.clr_cmd_rdy = 1'b0;
    check({nm, " rdy drop"}, {15'd0, if24.cmd_rdy}, 16'd0);
    if24.send_resp = 1'b1;
    #1;
    if (if24.resp_out) resp_cnt++;
    check({nm, " resp_out"}, {15'd0, if24.resp_out}, {15'd0, exp_resp});
    tick();
    if24.send_resp = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tour_tbl[i] = 8'h00;
    for (int i = 0; i < 24; i++) tour_tbl[i] = 8'h01 << ((i * 3) % 8);
    exp_v[0] = 16'h2002; exp_h[0] = 16'h33F1;
    exp_v[1] = 16'h2002; exp_h[1] = 16'h3BF1;
    exp_v[2] = 16'h2001; exp_h[2] = 16'h33F2;
    exp_v[3] = 16'h27F1; exp_h[3] = 16'h33F2;
    exp_v[4] = 16'h27F2; exp_h[4] = 16'h33F1;
    exp_v[5] = 16'h27F2; exp_h[5] = 16'h3BF1;
    exp_v[6] = 16'h27F1; exp_h[6] = 16'h3BF2;
    exp_v[7] = 16'h2001; exp_h[7] = 16'h3BF2;

    vecs[0] = '{16'h2005, 1'b1, 1'b0, 1'b0, 16'h2005, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h2005, 1'b1, 1'b1, 1'b0, 16'h2005, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'hABCD, 1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h5A3C, 1'b0, 1'b0, 1'b0, 16'h5A3C, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    if24.start_tour = 1'b0; if24.cmd_UART = 16'h0; if24.cmd_rdy_UART = 1'b0;
    if24.clr_cmd_rdy = 1'b0; if24.send_resp = 1'b0;
    if1.start_tour = 1'b0; if1.cmd_UART = 16'h0; if1.cmd_rdy_UART = 1'b0;
    if1.clr_cmd_rdy = 1'b0; if1.send_resp = 1'b0;
    #1;
    check("reset mv_indx", {11'd0, if24.mv_indx}, 16'd0);
    check("reset busy", {15'd0, if24.tour_busy}, 16'd0);
    check("reset busy n1", {15'd0, if1.tour_busy}, 16'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // IDLE passthrough vectors
    for (int i = 0; i < 6; i++) begin
      if24.cmd_UART     = vecs[i].cmd_uart;
      if24.cmd_rdy_UART = vecs[i].rdy_uart;
      if24.clr_cmd_rdy  = vecs[i].clr;
      if24.send_resp    = vecs[i].resp;
      #1;
      check($sformatf("vec%0d cmd", i), if24.cmd, vecs[i].e_cmd);
      check($sformatf("vec%0d rdy", i), {15'd0, if24.cmd_rdy}, {15'd0, vecs[i].e_rdy});
      check($sformatf("vec%0d clr_uart", i), {15'd0, if24.clr_cmd_rdy_UART}, {15'd0, vecs[i].e_clr_uart});
      check($sformatf("vec%0d resp", i), {15'd0, if24.resp_out}, {15'd0, vecs[i].e_resp});
      tick();
      check($sformatf("vec%0d busy", i), {15'd0, if24.tour_busy}, 16'd0);
    end
    if24.cmd_rdy_UART = 1'b0; if24.clr_cmd_rdy = 1'b0; if24.send_resp = 1'b0;

    // Single-move tour, NUM_MOVES=1
    if1.start_tour = 1'b1;
    tick();
    if1.start_tour = 1'b0;
    check("n1 v rdy", {15'd0, if1.cmd_rdy}, 16'd1);
    check("n1 v cmd", if1.cmd, 16'h2002);
    check("n1 busy", {15'd0, if1.tour_busy}, 16'd1);
    if1.clr_cmd_rdy = 1'b1; if1.send_resp = 1'b1;
    #1;
    check("n1 v resp suppressed", {15'd0, if1.resp_out}, 16'd0);
    tick();
    if1.clr_cmd_rdy = 1'b0; if1.send_resp = 1'b0;
    check("n1 clr+resp only clr", {15'd0, if1.cmd_rdy}, 16'd0);
    if1.start_tour = 1'b1;
    tick();
    if1.start_tour = 1'b0;
    check("n1 start ignored", {15'd0, if1.cmd_rdy}, 16'd0);
    if1.send_resp = 1'b1;
    #1;
    check("n1 wait_v resp", {15'd0, if1.resp_out}, 16'd0);
    tick();
    if1.send_resp = 1'b0;
    check("n1 h rdy", {15'd0, if1.cmd_rdy}, 16'd1);
    check("n1 h cmd", if1.cmd, 16'h3BF1);
    if1.clr_cmd_rdy = 1'b1;
    tick();
    if1.clr_cmd_rdy = 1'b0;
    check("n1 h rdy drop", {15'd0, if1.cmd_rdy}, 16'd0);
    if1.send_resp = 1'b1;
    #1;
    check("n1 final resp", {15'd0, if1.resp_out}, 16'd1);
    tick();
    if1.send_resp = 1'b0;
    check("n1 busy end", {15'd0, if1.tour_busy}, 16'd0);

    // Full tour with a UART command pending from the start cycle
    resp_cnt = 0;
    if24.cmd_UART = 16'h1234; if24.cmd_rdy_UART = 1'b1;
    if24.start_tour = 1'b1; if24.clr_cmd_rdy = 1'b1;
    #1;
    check("start-cycle clr passthrough", {15'd0, if24.clr_cmd_rdy_UART}, 16'd1);
    tick();
    if24.start_tour = 1'b0; if24.clr_cmd_rdy = 1'b0;
    for (int i = 0; i < 24; i++) begin
      int b;
      b = (i * 3) % 8;
      leg($sformatf("m%0d V", i), exp_v[b], 5'(i), 1'b0);
      leg($sformatf("m%0d H", i), exp_h[b], 5'(i), (i == 23));
    end
    check("tour busy end", {15'd0, if24.tour_busy}, 16'd0);
    check("tour resp count", resp_cnt[15:0], 16'd1);
    check("uart served cmd", if24.cmd, 16'h1234);
    check("uart served rdy", {15'd0, if24.cmd_rdy}, 16'd1);
    if24.clr_cmd_rdy = 1'b1;
    #1;
    check("uart served clr", {15'd0, if24.clr_cmd_rdy_UART}, 16'd1);
    tick();
    if24.clr_cmd_rdy = 1'b0; if24.cmd_rdy_UART = 1'b0;

    // Reset in WAIT_V at mv_indx 7
    if24.start_tour = 1'b1;
    tick();
    if24.start_tour = 1'b0;
    for (int i = 0; i < 7; i++) begin
      int b;
      b = (i * 3) % 8;
      leg($sformatf("r%0d V", i), exp_v[b], 5'(i), 1'b0);
      leg($sformatf("r%0d H", i), exp_h[b], 5'(i), 1'b0);
    end
    if24.clr_cmd_rdy = 1'b1;
    tick();
    if24.clr_cmd_rdy = 1'b0;
    check("pre-reset mv_indx", {11'd0, if24.mv_indx}, 16'd7);
    check("pre-reset rdy", {15'd0, if24.cmd_rdy}, 16'd0);
    if24.cmd_UART = 16'h0F0F; if24.cmd_rdy_UART = 1'b1;
    rst = 1'b1;
    #1;
    check("rst mv_indx", {11'd0, if24.mv_indx}, 16'd0);
    check("rst busy", {15'd0, if24.tour_busy}, 16'd0);
    check("rst rdy passthrough", {15'd0, if24.cmd_rdy}, 16'd1);
    check("rst cmd passthrough", if24.cmd, 16'h0F0F);
    tick();
    rst = 1'b0;
    if24.cmd_rdy_UART = 1'b0;
    tick();
    tick();
    check("post-rst rdy", {15'd0, if24.cmd_rdy}, 16'd0);
    check("post-rst busy", {15'd0, if24.tour_busy}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Sequences a solved knight's tour into drive commands for the motion command processor.
- After the tour solver signals completion, it reads the stored moves one at a time through the solver's move-index port. Each L-shaped move becomes two commands, a vertical leg then a horizontal leg, presented to the command processor with a ready/clear/response handshake.
- When no tour is in progress, it passes UART-originated commands and handshakes straight through to the command processor.

Parameters:
- NUM_MOVES, 24, number of moves read out per tour (indices 0..NUM_MOVES-1).
- MV_OP, 4'b0010, opcode for the vertical leg (plain move).
- FAN_OP, 4'b0011, opcode for the horizontal leg (move with fanfare).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_tour  in  1  1-cycle pulse from the solver's done; begins a tour.
- move  in  8  one-hot move from the solver, combinationally addressed by mv_indx.
- mv_indx  out  5  registered move index driven to the solver.
- cmd_UART  in  16  command from the UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy_UART  out  1  acknowledge to the UART wrapper.
- cmd  out  16  command to the processor: {opcode[15:12], heading[11:4], squares[3:0]}.
- cmd_rdy  out  1  cmd valid.
- clr_cmd_rdy  in  1  processor has accepted cmd.
- send_resp  in  1  processor finished executing a command.
- resp_out  out  1  response pulse forwarded toward the UART.
- tour_busy  out  1  high while a tour is being sequenced.

Behaviour:
- Reset values: state IDLE, mv_indx 0, tour_busy 0. In IDLE, outputs follow the passthrough rules below.
- Move decode (bit -> dx,dy): b0(-1,+2) b1(+1,+2) b2(-2,+1) b3(-2,-1) b4(-1,-2) b5(+1,-2) b6(+2,-1) b7(+2,+1).
- Vertical leg command: {MV_OP, dy>0 ? 8'h00 (N) : 8'h7F (S), |dy|}.
- Horizontal leg command: {FAN_OP, dx>0 ? 8'hBF (E) : 8'h3F (W), |dx|}.
- Non-one-hot move values are out of contract. The decoder gives lowest-set-bit priority; 8'h00 yields squares=0 on both legs, and both commands are still issued.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
- IDLE:
  - cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = clr_cmd_rdy, resp_out = send_resp (combinational passthrough).
  - start_tour -> VERT, with mv_indx <= 0 and tour_busy <= 1.
- VERT: cmd = vertical command of move, cmd_rdy = 1. clr_cmd_rdy -> WAIT_V.
- WAIT_V: cmd_rdy = 0. send_resp -> HORZ. resp_out is held 0.
- HORZ: cmd = horizontal command, cmd_rdy = 1. clr_cmd_rdy -> WAIT_H.
- WAIT_H, on send_resp:
  - If mv_indx == NUM_MOVES-1: go to IDLE, tour_busy <= 0, resp_out = 1 for that one cycle.
  - Otherwise: mv_indx <= mv_indx+1, go to VERT, resp_out = 0.
- Latency:
  - start_tour to cmd_rdy high: 1 clk.
  - clr_cmd_rdy to cmd_rdy low: 1 clk.
  - send_resp to next leg's cmd_rdy high: 1 clk.
- mv_indx changes only on the WAIT_H->VERT transition, so move is stable throughout both legs.
- While not IDLE:
  - clr_cmd_rdy_UART = 0. A pending UART command is held off, not dropped, and is served after the tour returns to IDLE.
  - Intermediate send_resp pulses are suppressed: exactly one resp_out pulse per tour.
- Simultaneous events:
  - start_tour and cmd_rdy_UART in the same IDLE cycle: the tour wins; that cycle's passthrough of clr_cmd_rdy still applies.
  - start_tour while not IDLE: ignored.
  - clr_cmd_rdy or send_resp in a state that does not expect it: ignored.
  - clr_cmd_rdy and send_resp together in VERT or HORZ: only clr_cmd_rdy acts.
- Reset mid-tour forces IDLE, mv_indx 0 and tour_busy 0 immediately. No command or response is emitted afterwards.

Test Plan:
- Passthrough: in IDLE, cmd_UART=16'h2005 with cmd_rdy_UART=1 -> cmd=16'h2005, cmd_rdy=1; pulse clr_cmd_rdy -> clr_cmd_rdy_UART pulses the same cycle.
- Single-move decode: NUM_MOVES=1, move=8'h02 -> cmd 16'h2002 (N, 2), then 16'h3BF1 (E, 1); resp_out pulses once after the second send_resp.
- Decode sweep: model the solver array with 24 entries covering all 8 bits -> the bench sees 48 commands matching the table, mv_indx steps 0..23, tour_busy falls when resp_out pulses.
- Response suppression: full tour -> exactly one resp_out pulse; 47 send_resp pulses are not forwarded.
- Arbitration: cmd_rdy_UART held high from the start_tour cycle -> clr_cmd_rdy_UART stays 0 during the tour; the UART cmd is served in the first IDLE cycle after the tour.
- Reset mid-tour: assert rst in WAIT_V at mv_indx=7 -> next cycle state IDLE, mv_indx=0, tour_busy=0, cmd_rdy follows cmd_rdy_UART.
